// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   size_e  : request access size (byte/half/word/double)
//   err_e   : response error code
//   state_e : LSU control FSM states
//   lsu_misaligned() : flags misaligned or unsupported-size requests
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_BUS      = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // A double access is only legal on a 64-bit datapath (dbl_ok).
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [2:0] addr_lo,
                                          input logic       dbl_ok);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = |addr_lo[1:0];
      default: bad = (|addr_lo) | ~dbl_ok;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the LSU.
//   Store side: masks store data to the access size and shifts it into its
//   byte lanes; generates the matching byte strobes.
//   Load side: shifts read data down from its lanes, masks it to the access
//   size and sign- or zero-extends to XLEN.
// Ports:
//   size_i     access size (size_e encoding)
//   unsigned_i zero-extend loads when set
//   off_i      byte offset within the bus word
//   wdata_i    LSB-justified store data       -> wdata_o lane-shifted data
//                                              -> wstrb_o byte enables
//   rdata_i    raw bus read data              -> rdata_o extended load data
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NB    = XLEN / 8,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [NB-1:0]    wstrb_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  rdata_o
);

  int              nbytes;
  logic [NB-1:0]   strb_base;
  logic [XLEN-1:0] data_base;
  logic [XLEN-1:0] rd_shift;
  logic            sign_bit;

  always_comb begin
    // A double on a 32-bit datapath never reaches the bus; clamping keeps
    // the lane math in range anyway.
    nbytes = 1 << size_i;
    if (nbytes > NB) nbytes = NB;

    for (int i = 0; i < NB; i++) strb_base[i] = (i < nbytes);
    for (int i = 0; i < XLEN; i++) data_base[i] = wdata_i[i] & (i < nbytes * 8);

    wstrb_o = strb_base << off_i;
    wdata_o = data_base << {off_i, 3'b000};

    rd_shift = rdata_i >> {off_i, 3'b000};
    case (size_i)
      SZ_B:    sign_bit = rd_shift[7];
      SZ_H:    sign_bit = rd_shift[15];
      SZ_W:    sign_bit = rd_shift[31];
      default: sign_bit = rd_shift[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++)
      rdata_o[i] = (i < nbytes * 8) ? rd_shift[i] : (sign_bit & ~unsigned_i);
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the core datapath and a single data-memory /
// MMIO bus. One request in flight at a time.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   req_*  : request handshake from the core (valid/ready, we, size,
//            unsigned, addr, wdata)
//   resp_* : one-cycle completion pulse with extended load data and error
//   busy_o : high while a transaction is in flight (through the resp cycle)
//   bus_*  : address phase (valid/ready, we, addr, wstrb, wdata) and
//            response phase (rvalid, rdata, err)
// Optional build macro LSU_TIMEOUT_EN: abort a transaction with ERR_TIMEOUT
// after TIMEOUT_CYCLES cycles waiting in the address or data phase.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [XLEN-1:0]     req_wdata_i,
  output logic                resp_valid_o,
  output logic [XLEN-1:0]     resp_rdata_o,
  output logic [1:0]          resp_err_o,
  output logic                busy_o,
  output logic                bus_valid_o,
  input  logic                bus_ready_i,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [XLEN/8-1:0]   bus_wstrb_o,
  output logic [XLEN-1:0]     bus_wdata_o,
  input  logic                bus_rvalid_i,
  input  logic [XLEN-1:0]     bus_rdata_i,
  input  logic                bus_err_i
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic [NB-1:0]     lane_strb;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   load_ext;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             timed_out;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign timed_out = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
`endif

  // Lane steering works off the latched request so the bus outputs hold
  // steady for the whole address phase.
  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .off_i      (addr_q[OFF_W-1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (bus_rdata_i),
    .wstrb_o    (lane_strb),
    .wdata_o    (lane_wdata),
    .rdata_o    (load_ext)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_we_i ? req_wdata_i : '0;
          rdata_d = '0;
          if (lsu_misaligned(req_size_i, req_addr_i[2:0], XLEN == 64)) begin
            state_d = ST_RESP;
            err_d   = ERR_MISALIGN;
          end else begin
            state_d = ST_ADDR;
            err_d   = ERR_NONE;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      ST_ADDR: begin
        if (bus_ready_i) begin
          state_d = ST_DATA;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d = ST_RESP;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d   = cnt_inc;
`endif
        end
      end

      ST_DATA: begin
        // Stores complete on the same beat; only clean loads return data.
        if (bus_rvalid_i) begin
          state_d = ST_RESP;
          err_d   = bus_err_i ? ERR_BUS : ERR_NONE;
          rdata_d = (!we_q && !bus_err_i) ? load_ext : '0;
`ifdef LSU_TIMEOUT_EN
        end else if (timed_out) begin
          state_d = ST_RESP;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d   = cnt_inc;
`endif
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Request and load-data holding registers; every output that exposes them
  // is gated by state, so they need no reset.
  always_ff @(posedge clk_i) begin
    we_q    <= we_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_err_o   = resp_valid_o ? err_q : ERR_NONE;
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;

  assign bus_valid_o  = (state_q == ST_ADDR);
  assign bus_we_o     = bus_valid_o & we_q;
  assign bus_addr_o   = bus_valid_o ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus_wstrb_o  = bus_valid_o ? lane_strb : '0;
  assign bus_wdata_o  = bus_valid_o ? lane_wdata : '0;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic [1:0]  resp_err_o;
  logic        busy_o;
  logic        bus_valid_o;
  logic        bus_ready_i;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_wstrb_o;
  logic [31:0] bus_wdata_o;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  lsu #(
    .XLEN           (32),
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .busy_o         (busy_o),
    .bus_valid_o    (bus_valid_o),
    .bus_ready_i    (bus_ready_i),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wstrb_o    (bus_wstrb_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rvalid_i   (bus_rvalid_i),
    .bus_rdata_i    (bus_rdata_i),
    .bus_err_i      (bus_err_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One full transaction. The bus side is driven by the bench: address phase
  // accepted after rdly wait cycles, response beat after vdly wait cycles.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input logic berr,
                         input int rdly, input int vdly);
    longint unsigned nb, off, mask, v, e_strb, e_wd, e_rd;
    logic            mis;
    logic [1:0]      e_err;

    // Reference model from plain arithmetic on the request.
    nb     = longint'(1) << sz;
    off    = longint'(addr % 4);
    mis    = (sz == 2'd3) || ((addr % nb) != 0);
    mask   = (longint'(1) << (8 * nb)) - 1;
    e_strb = (((longint'(1) << nb) - 1) << off) & 64'hF;
    e_wd   = we ? (((longint'(wd) & mask) << (8 * off)) & 64'hFFFF_FFFF) : 0;
    v      = (longint'(rd) >> (8 * off)) & mask;
    if (!uns && ((v >> (8 * nb - 1)) & 1) == 1) v = v | ~mask;
    e_rd   = (we || berr) ? 0 : (v & 64'hFFFF_FFFF);
    e_err  = berr ? 2'd2 : 2'd0;

    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wd;
    check("req_ready_idle", req_ready_o, 1);
    step();
    // Scramble request inputs: the unit must work from its latched copy.
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_we_i    = ~we;

    if (mis) begin
      check("mis_resp_valid", resp_valid_o, 1);
      check("mis_err", resp_err_o, 1);
      check("mis_rdata", resp_rdata_o, 0);
      check("mis_bus_valid", bus_valid_o, 0);
    end else begin
      for (int i = 0; i <= rdly; i++) begin
        check("bus_valid", bus_valid_o, 1);
        check("bus_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
        check("bus_wstrb", bus_wstrb_o, e_strb);
        check("bus_wdata", bus_wdata_o, e_wd);
        check("bus_we", bus_we_o, we);
        check("addr_busy", busy_o, 1);
        check("addr_req_ready", req_ready_o, 0);
        check("addr_resp_valid", resp_valid_o, 0);
        bus_ready_i = (i == rdly);
        step();
      end
      bus_ready_i = 1'b0;
      for (int i = 0; i <= vdly; i++) begin
        check("data_bus_valid", bus_valid_o, 0);
        check("data_resp_valid", resp_valid_o, 0);
        bus_rvalid_i = (i == vdly);
        bus_rdata_i  = (i == vdly) ? rd : $urandom;
        bus_err_i    = (i == vdly) ? berr : 1'b0;
        step();
      end
      bus_rvalid_i = 1'b0;
      bus_err_i    = 1'b0;
      check("resp_valid", resp_valid_o, 1);
      check("resp_err", resp_err_o, e_err);
      check("resp_rdata", resp_rdata_o, e_rd);
      check("resp_busy", busy_o, 1);
    end
    step();
    check("post_resp_valid", resp_valid_o, 0);
    check("post_req_ready", req_ready_o, 1);
    check("post_busy", busy_o, 0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] nb;

    rst_i          = 1'b1;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    bus_ready_i    = 1'b0;
    bus_rvalid_i   = 1'b0;
    bus_rdata_i    = '0;
    bus_err_i      = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;

    check("rst_req_ready", req_ready_o, 1);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_bus_valid", bus_valid_o, 0);
    check("rst_bus_we", bus_we_o, 0);
    check("rst_resp_err", resp_err_o, 0);
    check("rst_resp_rdata", resp_rdata_o, 0);
    check("rst_bus_addr", bus_addr_o, 0);
    check("rst_bus_wstrb", bus_wstrb_o, 0);
    check("rst_bus_wdata", bus_wdata_o, 0);

    // Directed cases.
    run_txn(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1'b0, 0, 0);
    run_txn(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 1'b0, 0, 0);
    run_txn(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 1'b0, 0, 0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_1002, 32'h0, 32'h0, 1'b0, 0, 0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 2);
    run_txn(1'b0, 2'd3, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 1'b0, 0, 0);
    run_txn(1'b1, 2'd2, 1'b0, 32'h0000_5004, 32'h1234_5678, 32'h0, 1'b0, 2, 1);

    // Stray response beat while idle must not produce a response.
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hCAFE_F00D;
    step();
    bus_rvalid_i = 1'b0;
    check("stray_resp_valid", resp_valid_o, 0);
    check("stray_req_ready", req_ready_o, 1);
    step();
    check("stray_resp_valid2", resp_valid_o, 0);

    // Reset while waiting in the data phase aborts silently.
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_size_i  = 2'd2;
    req_addr_i  = 32'h0000_3000;
    step();
    req_valid_i = 1'b0;
    bus_ready_i = 1'b1;
    step();
    bus_ready_i = 1'b0;
    check("abort_in_data", bus_valid_o, 0);
    check("abort_busy", busy_o, 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("abort_req_ready", req_ready_o, 1);
    check("abort_resp_valid", resp_valid_o, 0);
    check("abort_busy_low", busy_o, 0);
    check("abort_bus_valid", bus_valid_o, 0);
    bus_rvalid_i = 1'b1;
    step();
    bus_rvalid_i = 1'b0;
    check("abort_late_beat", resp_valid_o, 0);
    step();
    check("abort_late_beat2", resp_valid_o, 0);
    run_txn(1'b0, 2'd0, 1'b0, 32'h0000_3001, 32'h0, 32'h0000_F500, 1'b0, 0, 0);

`ifdef LSU_TIMEOUT_EN
    // Address phase never accepted: 16 cycles of bus_valid, then timeout.
    begin
      int addr_cycles;
      logic seen;
      addr_cycles = 0;
      seen = 1'b0;
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_size_i  = 2'd2;
      req_addr_i  = 32'h0000_6000;
      step();
      req_valid_i = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        if (resp_valid_o) seen = 1'b1;
        else begin
          if (bus_valid_o) addr_cycles++;
          step();
        end
      end
      check("to_seen", seen, 1);
      check("to_addr_cycles", addr_cycles, 16);
      check("to_err", resp_err_o, 3);
      check("to_rdata", resp_rdata_o, 0);
      check("to_bus_valid", bus_valid_o, 0);
      bus_rvalid_i = 1'b1;
      step();
      bus_rvalid_i = 1'b0;
      check("to_bus_valid_after", bus_valid_o, 0);
      check("to_late_beat", resp_valid_o, 0);
      step();
      check("to_late_beat2", resp_valid_o, 0);
    end
`endif

    // Randomized traffic, mostly aligned.
    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      nb = 32'd1 << sz;
      if ($urandom_range(0, 3) != 0) a = a & ~(nb - 32'd1);
      run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
              $urandom, $urandom, ($urandom_range(0, 7) == 0),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
